agc_gain_controller: RTL

Closed-loop automatic gain controller that generates the 8-bit `gain_control` word consumed by `adaptive_gain_scaler`. It observes the scaler's output samples and averages their magnitude over a fixed window. It compares the average against a programmable target with hysteresis, then steps the gain code up or down. A settle interval after every decision lets the scaler pipeline flush before the next measurement.

---
 rtl/agc_gain_controller.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/agc_gain_controller.sv
// agc_gain_controller
// Closed-loop automatic gain controller for adaptive_gain_scaler. Averages
// |sample_in| over 2^WINDOW_LOG2 valid samples, compares the mean against
// target_level +/- HYST and steps gain_control down/up by STEP. After each
// decision a SETTLE interval of HOLD_CYCLES cycles ignores samples.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   sample_in         : signed scaler output sample (DATA_WIDTH)
//   sample_valid_in   : sample_in qualifier
//   enable            : loop enable; low returns to IDLE and discards the window
//   target_level      : unsigned target mean magnitude, sampled in DECIDE
//   gain_control      : 8-bit gain code, higher = more gain
//   gain_update       : one-cycle pulse when gain_control changes
//   level_out         : last measured mean magnitude
//   level_valid       : one-cycle pulse when level_out updates
//   locked            : last decision was in-band
//   at_limit          : gain_control equals GAIN_MIN or GAIN_MAX
//
// Optional feature macro: AGC_FAST_ATTACK_EN
//   When defined, a full-scale sample during ACCUM aborts the window and
//   immediately drops the gain by 4*STEP, then enters SETTLE.
module agc_gain_controller #(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           WINDOW_LOG2 = 8,
  parameter logic [DATA_WIDTH-1:0] HYST        = DATA_WIDTH'(32'h100),
  parameter logic [7:0]            GAIN_INIT   = 8'h40,
  parameter logic [7:0]            GAIN_MIN    = 8'h00,
  parameter logic [7:0]            GAIN_MAX    = 8'hFF,
  parameter int unsigned           STEP        = 1,
  parameter int unsigned           HOLD_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid_in,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] target_level,
  output logic [7:0]            gain_control,
  output logic                  gain_update,
  output logic [DATA_WIDTH-1:0] level_out,
  output logic                  level_valid,
  output logic                  locked,
  output logic                  at_limit
);

  localparam int unsigned AW = DATA_WIDTH + WINDOW_LOG2;
  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [DATA_WIDTH-1:0] MAX_POS  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [15:0]           STEP_W   = 16'(STEP);
`ifdef AGC_FAST_ATTACK_EN
  localparam logic [15:0]           STEP4_W  = 16'(4 * STEP);
`endif
  localparam logic AT_LIMIT_INIT = (GAIN_INIT == GAIN_MIN) || (GAIN_INIT == GAIN_MAX);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCUM  = 2'd1;
  localparam logic [1:0] DECIDE = 2'd2;
  localparam logic [1:0] SETTLE = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [AW-1:0]          acc_q, acc_d;
  logic [WINDOW_LOG2-1:0] cnt_q, cnt_d;
  logic                   full_q, full_d;
  logic [DATA_WIDTH-1:0]  mag_q, mag_d;
  logic                   mag_vld_q, mag_vld_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic [7:0]             gain_q, gain_d;
  logic                   gain_update_q, gain_update_d;
  logic [DATA_WIDTH-1:0]  level_q, level_d;
  logic                   level_valid_q, level_valid_d;
  logic                   locked_q, locked_d;
  logic                   at_limit_q, at_limit_d;

  logic [DATA_WIDTH-1:0]  mag_c, lo_c, hi_c, hi_sum_c, mean_c;
  logic                   hi_carry_c;

  // Gain step with clamping; 16-bit arithmetic keeps large STEP values safe.
  function automatic logic [7:0] step_dn(input logic [7:0] g, input logic [15:0] s);
    logic [15:0] room;
    room = {8'h00, g} - {8'h00, GAIN_MIN};
    if (g <= GAIN_MIN)  step_dn = GAIN_MIN;
    else if (room >= s) step_dn = 8'({8'h00, g} - s);
    else                step_dn = GAIN_MIN;
  endfunction

  function automatic logic [7:0] step_up(input logic [7:0] g, input logic [15:0] s);
    logic [15:0] room;
    room = {8'h00, GAIN_MAX} - {8'h00, g};
    if (g >= GAIN_MAX)  step_up = GAIN_MAX;
    else if (room >= s) step_up = 8'({8'h00, g} + s);
    else                step_up = GAIN_MAX;
  endfunction

  // Saturating magnitude: the most negative code maps to the largest positive.
  always_comb begin
    if (sample_in == MOST_NEG)        mag_c = MAX_POS;
    else if (sample_in[DATA_WIDTH-1]) mag_c = -sample_in;
    else                              mag_c = sample_in;
  end

  // Deadzone bounds: lo floors at zero, hi saturates to all-ones.
  always_comb begin
    lo_c                   = (target_level > HYST) ? (target_level - HYST) : '0;
    {hi_carry_c, hi_sum_c} = {1'b0, target_level} + {1'b0, HYST};
    hi_c                   = hi_carry_c ? '1 : hi_sum_c;
    mean_c                 = acc_q[AW-1:WINDOW_LOG2];
  end

  // Next-state and datapath.
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    full_d        = full_q;
    mag_d         = mag_q;
    mag_vld_d     = 1'b0;
    hold_d        = hold_q;
    gain_d        = gain_q;
    gain_update_d = 1'b0;
    level_d       = level_q;
    level_valid_d = 1'b0;
    locked_d      = locked_q;

    // Magnitudes are registered one cycle before being accumulated.
    if (mag_vld_q) acc_d = acc_q + AW'(mag_q);

    if (!enable) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      full_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
          full_d  = 1'b0;
        end
        ACCUM: begin
          if (full_q) begin
            // Final magnitude lands in the accumulator on this edge.
            state_d = DECIDE;
          end else if (sample_valid_in) begin
`ifdef AGC_FAST_ATTACK_EN
            if (mag_c == MAX_POS) begin
              gain_d        = step_dn(gain_q, STEP4_W);
              gain_update_d = (gain_d != gain_q);
              locked_d      = 1'b0;
              acc_d         = '0;
              cnt_d         = '0;
              if (HOLD_CYCLES == 0) begin
                state_d = ACCUM;
              end else begin
                state_d = SETTLE;
                hold_d  = '0;
              end
            end else
`endif
            begin
              mag_d     = mag_c;
              mag_vld_d = 1'b1;
              cnt_d     = cnt_q + 1'b1;
              full_d    = &cnt_q;
            end
          end
        end
        DECIDE: begin
          level_d       = mean_c;
          level_valid_d = 1'b1;
          if (mean_c > hi_c) begin
            gain_d   = step_dn(gain_q, STEP_W);
            locked_d = 1'b0;
          end else if (mean_c < lo_c) begin
            gain_d   = step_up(gain_q, STEP_W);
            locked_d = 1'b0;
          end else begin
            locked_d = 1'b1;
          end
          gain_update_d = (gain_d != gain_q);
          acc_d         = '0;
          cnt_d         = '0;
          full_d        = 1'b0;
          if (HOLD_CYCLES == 0) begin
            state_d = ACCUM;
          end else begin
            state_d = SETTLE;
            hold_d  = '0;
          end
        end
        SETTLE: begin
          if (32'(hold_q) + 32'd1 >= HOLD_CYCLES) state_d = ACCUM;
          else                                    hold_d  = hold_q + 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end

    at_limit_d = (gain_d == GAIN_MIN) || (gain_d == GAIN_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      cnt_q         <= '0;
      full_q        <= 1'b0;
      mag_q         <= '0;
      mag_vld_q     <= 1'b0;
      hold_q        <= '0;
      gain_q        <= GAIN_INIT;
      gain_update_q <= 1'b0;
      level_q       <= '0;
      level_valid_q <= 1'b0;
      locked_q      <= 1'b0;
      at_limit_q    <= AT_LIMIT_INIT;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      full_q        <= full_d;
      mag_q         <= mag_d;
      mag_vld_q     <= mag_vld_d;
      hold_q        <= hold_d;
      gain_q        <= gain_d;
      gain_update_q <= gain_update_d;
      level_q       <= level_d;
      level_valid_q <= level_valid_d;
      locked_q      <= locked_d;
      at_limit_q    <= at_limit_d;
    end
  end

  assign gain_control = gain_q;
  assign gain_update  = gain_update_q;
  assign level_out    = level_q;
  assign level_valid  = level_valid_q;
  assign locked       = locked_q;
  assign at_limit     = at_limit_q;

endmodule
